sim_mem_pipelined: RTL and testbench
====================================

# sim_mem_pipelined

Parametrised, clocked simulation memory model for the RV32I core and its bench, replacing the combinational single-word memory model. Supports configurable data width, depth and fixed response latency. Uses a valid/ready request channel, a valid/ready response channel with a bounded response queue, per-byte write masks, and out-of-range error reporting. Sits between the core's load/store/fetch port and the testbench, so memory timing can be varied without touching the core.

## Interface
- `DATA_WIDTH`, 32: word width in bits; multiple of 8; `NBYTES = DATA_WIDTH/8`, a power of 2.
- `ADDR_WIDTH`, 32: byte-address width.
- `DEPTH_LOG2`, 14: memory holds `2**DEPTH_LOG2` words.
- `LATENCY`, 2: cycles from request accept to earliest response; ≥ 1.
- `RESP_DEPTH`, 4: maximum outstanding requests (pipeline plus queue); power of 2, ≥ `LATENCY`.
- `INIT_FILE`, "": if non-empty, loaded with `$readmemh` at time 0.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted.
- `req_cmd` in 1: `MEM_CMD_READ` or `MEM_CMD_WRITE`.
- `req_addr` in ADDR_WIDTH: byte address; low `log2(NBYTES)` bits ignored.
- `req_mask` in NBYTES: byte-lane write enables; ignored for reads.
- `req_wdata` in DATA_WIDTH: write data.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes response.
- `resp_cmd` out 1: command of the request being answered.
- `resp_rdata` out DATA_WIDTH: read data; 0 for writes and errors.
- `resp_err` out 1: address was out of range.

## Operation
- Accept: `req_valid && req_ready` at a rising edge.
- Word index: `req_addr[ADDR_WIDTH-1:log2(NBYTES)]`. An index ≥ `2**DEPTH_LOG2` is an error.
- The memory array is accessed only at the accept edge, so requests complete strictly in acceptance order.
  - Write: for each lane i with `req_mask[i]` set, byte i of the word takes byte i of `req_wdata`. Other bytes are unchanged.
  - Read: captures the word as it stood before that edge. A read accepted one cycle after a write to the same word returns the new data.
- Error requests do not modify memory. They respond with `resp_err=1` and `rdata=0`.
- An all-zero mask write is legal: no memory change, normal response.
- Each accepted request produces exactly one response carrying `{cmd, rdata, err}`.
- Response path: a `LATENCY-1`-stage shift pipeline feeds a response FIFO of `RESP_DEPTH` entries. With `LATENCY=1`, the accept writes the FIFO directly.
- Outstanding counter `outst` (0..RESP_DEPTH):
  - +1 on accept; −1 on response pop (`resp_valid && resp_ready`).
  - Accept and pop in the same cycle leave it unchanged.
- `req_ready = (outst != RESP_DEPTH)`. This is a function of registered state only, with no combinational path from `resp_ready`.
- `resp_valid` = FIFO not empty. The response outputs come from the FIFO head and stay stable while `resp_valid && !resp_ready`.
- Reset values: `req_ready=1`, `resp_valid=0`, `resp_cmd=0`, `resp_rdata=0`, `resp_err=0`.
- Reset clears `outst`, the pipeline valid bits and the FIFO pointers.
- Reset mid-operation: in-flight responses are dropped. Writes already accepted persist. Memory contents are never reset.

## Timing
- A request accepted at the end of cycle n, with `resp_ready` held high, shows `resp_valid` in exactly cycle n+LATENCY.
- Back-to-back accepts every cycle are sustained when `resp_ready=1`, giving throughput 1/cycle.
- With `resp_ready=0`, exactly `RESP_DEPTH` requests are accepted, then `req_ready` drops in the following cycle.
- `req_ready` rises the cycle after the first pop.
- FIFO full and empty are resolved by pointers with an extra wrap bit. Simultaneous push and pop on a full FIFO cannot occur, because `outst` forbids it.

## Structure
- `MEM_CMD_READ` and `MEM_CMD_WRITE` stay in `defines.vh`.
- Add `MEM_RESP_W`, the response-entry width `2+DATA_WIDTH`, as a define there only if the bench needs it.
- One sub-module: `sim_mem_resp_fifo` (parametrised width and depth; push, pop, full, empty, async active-low reset).
- The memory array, address decode, mask expansion, pipeline and `outst` counter live in the top.

## Test plan
- Write 0xDEADBEEF to 0x100 with mask 4'b1111, then read 0x100 → response `rdata=0xDEADBEEF`, `err=0`. With `LATENCY=2`, the read response arrives exactly 2 cycles after its accept.
- Write 0x000000AA to 0x100 with mask 4'b0001 over 0xDEADBEEF → a read returns 0xDEADBEAA. A write with mask 4'b0000 leaves it 0xDEADBEAA.
- Hold `resp_ready=0` and issue 6 reads with `RESP_DEPTH=4` → exactly 4 accepted and `req_ready=0`. Raise `resp_ready` → the 4 responses drain in order, the remaining 2 are accepted, and all 6 `rdata` values match.
- Read from word index `2**DEPTH_LOG2` (byte address 0x10000 at defaults) → `resp_err=1`, `rdata=0`. A write there → `err=1`, and a read of word 0 is unchanged.
- Stream 16 alternating write/read pairs to different addresses with `resp_ready` toggling pseudo-randomly → responses in order, data correct, no request lost or duplicated.
- Assert `rst_n=0` with 3 responses outstanding → next cycle `resp_valid=0` and `req_ready=1`. After release, a read of a previously written address returns the written data.

Source files
------------

// File: rtl/sim_mem_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_mem_pipelined_pkg
// Purpose  : Shared constants for the pipelined simulation memory model.
//            Command encodings used on req_cmd / resp_cmd.
// Revision : 1.0 - initial release
// ============================================================================
package sim_mem_pipelined_pkg;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

endpackage : sim_mem_pipelined_pkg
`default_nettype wire

// File: rtl/sim_mem_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sim_mem_resp_fifo
// Purpose  : Response queue for sim_mem_pipelined. Full/empty are resolved
//            with read/write pointers that carry an extra wrap bit.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            push, push_data  - write one entry (ignored when full)
//            pop              - drop the head entry (ignored when empty)
//            head             - head entry, forced to 0 when empty
//            full, empty      - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module sim_mem_resp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] storage [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is never reset, so the head is masked to keep the response
  // outputs at zero whenever nothing is queued.
  assign head = empty ? '0 : storage[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule : sim_mem_resp_fifo
`default_nettype wire

// File: rtl/sim_mem_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : sim_mem_pipelined
// Purpose  : Clocked simulation memory with valid/ready request and response
//            channels, fixed response latency, byte write masks and
//            out-of-range error reporting. Responses return in accept order.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            req_valid/req_ready          - request handshake
//            req_cmd, req_addr, req_mask,
//            req_wdata                    - request payload (byte address)
//            resp_valid/resp_ready        - response handshake
//            resp_cmd, resp_rdata,
//            resp_err                     - response payload
// Revision : 1.0 - initial release
// ============================================================================
module sim_mem_pipelined
  import sim_mem_pipelined_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 14,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_cmd,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_mask,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_cmd,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int NBYTES   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int ENTRY_W  = 2 + DATA_WIDTH;
  localparam int CNT_W    = $clog2(RESP_DEPTH) + 1;
  localparam logic [CNT_W-1:0] OUTST_MAX = CNT_W'(RESP_DEPTH);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  logic                  accept;
  logic                  pop;
  logic [IDX_W-1:0]      idx;
  logic [DEPTH_LOG2-1:0] word_sel;
  logic                  addr_err;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [ENTRY_W-1:0]    entry;
  logic                  fifo_push;
  logic [ENTRY_W-1:0]    fifo_push_data;
  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full_unused;
  logic                  unused_addr_lsb;
  logic [CNT_W-1:0]      outst;

  assign accept     = req_valid && req_ready;
  assign pop        = resp_valid && resp_ready;
  assign req_ready  = (outst != OUTST_MAX);
  assign resp_valid = !fifo_empty;

  // Byte offset inside a word is ignored.
  assign unused_addr_lsb = ^req_addr[ADDR_LSB-1:0];

  assign idx      = req_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign word_sel = idx[DEPTH_LOG2-1:0];
  assign addr_err = ((idx >> DEPTH_LOG2) != '0);

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      bit_mask[i*8 +: 8] = {8{req_mask[i]}};
    end
  end

  // Response entry {cmd, rdata, err} is formed at the accept edge from the
  // pre-edge memory contents; writes and errors carry zero data.
  assign entry = {req_cmd,
                  (addr_err || (req_cmd == MEM_CMD_WRITE)) ? '0 : mem[word_sel],
                  addr_err};

  always_ff @(posedge clk) begin
    if (accept && (req_cmd == MEM_CMD_WRITE) && !addr_err) begin
      mem[word_sel] <= (mem[word_sel] & ~bit_mask) | (req_wdata & bit_mask);
    end
  end

  // Outstanding requests = entries in the pipeline plus the queue. Bounding it
  // by RESP_DEPTH guarantees the queue can always absorb the pipeline output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign fifo_push      = accept;
      assign fifo_push_data = entry;
    end else begin : g_pipe
      localparam int STAGES = LATENCY - 1;

      logic [STAGES-1:0]  pipe_valid;
      logic [ENTRY_W-1:0] pipe_data [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= accept;
          for (int s = 1; s < STAGES; s++) pipe_valid[s] <= pipe_valid[s-1];
        end
      end

      always_ff @(posedge clk) begin
        pipe_data[0] <= entry;
        for (int s = 1; s < STAGES; s++) pipe_data[s] <= pipe_data[s-1];
      end

      assign fifo_push      = pipe_valid[STAGES-1];
      assign fifo_push_data = pipe_data[STAGES-1];
    end
  endgenerate

  sim_mem_resp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty)
  );

  assign {resp_cmd, resp_rdata, resp_err} = fifo_head;

endmodule : sim_mem_pipelined
`default_nettype wire

// File: tb/tb_sim_mem_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_mem_pipelined
// Purpose  : Directed self-checking bench for sim_mem_pipelined at default
//            parameters (32-bit data, 2**14 words, LATENCY=2, RESP_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_mem_pipelined;
  import sim_mem_pipelined_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_cmd;
  logic [31:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_cmd;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Request/expectation tables for the streaming phases.
  logic        q_cmd   [64];
  logic [31:0] q_addr  [64];
  logic [3:0]  q_mask  [64];
  logic [31:0] q_wdata [64];
  logic [31:0] e_rdata [64];
  logic        e_err   [64];
  int n_req, sent, ridx;

  always #5 clk = ~clk;

  sim_mem_pipelined #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH_LOG2 (14),
    .LATENCY    (2),
    .RESP_DEPTH (4),
    .INIT_FILE  ("")
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_cmd   (resp_cmd),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted.
  task automatic send(input logic cmd, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] wdata);
    int n = 0;
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_mask = mask; req_wdata = wdata;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $error("FAIL send_timeout: req_ready observed=0 expected=1 addr=%h", addr);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Wait for one response, check it, and pop it.
  task automatic recv(input string tag, input logic cmd, input logic [31:0] rdata,
                      input logic err);
    int n = 0;
    resp_ready = 1'b1;
    while (!resp_valid && n < 200) begin tick(); n++; end
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk(tag, 64'({resp_cmd, resp_rdata, resp_err}), 64'({cmd, rdata, err}));
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic cmd, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    send(cmd, addr, mask, wdata);
    recv(tag, cmd, exp_rdata, exp_err);
  endtask

  task automatic drive_next();
    if (sent < n_req) begin
      req_valid = 1'b1;
      req_cmd   = q_cmd[sent];
      req_addr  = q_addr[sent];
      req_mask  = q_mask[sent];
      req_wdata = q_wdata[sent];
    end else begin
      req_valid = 1'b0;
    end
  endtask

  // One clock of the streaming engine; called at #1 after a rising edge.
  task automatic step(input bit rnd);
    logic acc, pop;
    if (rnd) resp_ready = 1'($urandom_range(0, 1));
    acc = req_valid && req_ready;
    pop = resp_valid && resp_ready;
    if (pop) begin
      if (ridx < n_req) begin
        chk($sformatf("stream_resp%0d", ridx),
            64'({resp_cmd, resp_rdata, resp_err}),
            64'({q_cmd[ridx], e_rdata[ridx], e_err[ridx]}));
      end else begin
        n_checks++; n_fail++;
        $error("FAIL stream_extra: observed response %0d expected none", ridx);
      end
      ridx++;
    end
    tick();
    if (acc) begin
      sent++;
      drive_next();
    end
  endtask

  task automatic run_until_done(input bit rnd, input int budget);
    int b = budget;
    while (ridx < n_req && b > 0) begin step(rnd); b--; end
    chk("stream_count", 64'(ridx), 64'(n_req));
    chk("stream_sent", 64'(sent), 64'(n_req));
    resp_ready = 1'b1;
    tick();
    chk("stream_drained", 64'(resp_valid), 64'd0);
    resp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 1'b0; req_addr = '0;
    req_mask = '0; req_wdata = '0; resp_ready = 1'b0;
    n_req = 0; sent = 0; ridx = 0;
    repeat (3) tick();

    // Reset state
    chk("rst_req_ready",  64'(req_ready),  64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data",  64'({resp_cmd, resp_rdata, resp_err}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full write, read back, response latency of 2
    txn("wr_full", MEM_CMD_WRITE, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    send(MEM_CMD_READ, 32'h100, 4'b0000, 32'h0);
    chk("lat_cycle1", 64'(resp_valid), 64'd0);
    tick();
    chk("lat_cycle2", 64'(resp_valid), 64'd1);
    recv("rd_full", MEM_CMD_READ, 32'hDEADBEEF, 1'b0);

    // Byte mask and empty mask
    txn("wr_lane0", MEM_CMD_WRITE, 32'h100, 4'b0001, 32'h000000AA, 32'h0, 1'b0);
    txn("rd_lane0", MEM_CMD_READ,  32'h100, 4'b0000, 32'h0, 32'hDEADBEAA, 1'b0);
    txn("wr_nomask", MEM_CMD_WRITE, 32'h100, 4'b0000, 32'h12345678, 32'h0, 1'b0);
    txn("rd_nomask", MEM_CMD_READ,  32'h101, 4'b0000, 32'h0, 32'hDEADBEAA, 1'b0);

    // Out-of-range: word index 2**14 aliases word 0 if the decode is wrong
    txn("wr_word0", MEM_CMD_WRITE, 32'h0, 4'b1111, 32'h0BADF00D, 32'h0, 1'b0);
    txn("rd_oor",   MEM_CMD_READ,  32'h10000, 4'b0000, 32'h0, 32'h0, 1'b1);
    txn("wr_oor",   MEM_CMD_WRITE, 32'h10000, 4'b1111, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("rd_word0", MEM_CMD_READ,  32'h0, 4'b0000, 32'h0, 32'h0BADF00D, 1'b0);

    // Backpressure: six reads with resp_ready low
    for (int k = 0; k < 6; k++) begin
      txn($sformatf("bp_fill%0d", k), MEM_CMD_WRITE, 32'h200 + 32'(4*k), 4'b1111,
          32'h10000000 + 32'(k), 32'h0, 1'b0);
    end
    n_req = 6; sent = 0; ridx = 0;
    for (int k = 0; k < 6; k++) begin
      q_cmd[k] = MEM_CMD_READ; q_addr[k] = 32'h200 + 32'(4*k); q_mask[k] = 4'b0000;
      q_wdata[k] = 32'h0; e_rdata[k] = 32'h10000000 + 32'(k); e_err[k] = 1'b0;
    end
    resp_ready = 1'b0;
    drive_next();
    repeat (10) step(1'b0);
    chk("bp_accepted",   64'(sent),       64'd4);
    chk("bp_req_ready",  64'(req_ready),  64'd0);
    chk("bp_resp_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    run_until_done(1'b0, 100);

    // Stream of write/read pairs with random response backpressure
    n_req = 32; sent = 0; ridx = 0;
    for (int k = 0; k < 16; k++) begin
      q_cmd[2*k]   = MEM_CMD_WRITE; q_addr[2*k]   = 32'h800 + 32'(12*k);
      q_mask[2*k]  = 4'b1111;       q_wdata[2*k]  = 32'hC0DE0000 | 32'(k * 32'h111);
      e_rdata[2*k] = 32'h0;         e_err[2*k]    = 1'b0;
      q_cmd[2*k+1]   = MEM_CMD_READ; q_addr[2*k+1]  = 32'h800 + 32'(12*k);
      q_mask[2*k+1]  = 4'b0000;      q_wdata[2*k+1] = 32'h0;
      e_rdata[2*k+1] = 32'hC0DE0000 | 32'(k * 32'h111); e_err[2*k+1] = 1'b0;
    end
    drive_next();
    run_until_done(1'b1, 400);

    // Reset with three responses outstanding
    txn("wr_keep", MEM_CMD_WRITE, 32'h300, 4'b1111, 32'h5A5A1234, 32'h0, 1'b0);
    resp_ready = 1'b0;
    send(MEM_CMD_READ, 32'h300, 4'b0000, 32'h0);
    send(MEM_CMD_READ, 32'h304, 4'b0000, 32'h0);
    send(MEM_CMD_READ, 32'h308, 4'b0000, 32'h0);
    chk("pre_rst_valid", 64'(resp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("in_rst_valid", 64'(resp_valid), 64'd0);
    chk("in_rst_ready", 64'(req_ready),  64'd1);
    tick();
    chk("rst_next_valid", 64'(resp_valid), 64'd0);
    chk("rst_next_ready", 64'(req_ready),  64'd1);
    rst_n = 1'b1;
    tick();
    txn("rd_after_rst", MEM_CMD_READ, 32'h300, 4'b0000, 32'h0, 32'h5A5A1234, 1'b0);
    chk("post_rst_idle", 64'(resp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sim_mem_pipelined
`default_nettype wire
